band_scheduler: RTL and testbench
=================================

BAND_SCHEDULER -- requirements
Module: band_scheduler

Interface
REQ-001 SHALL have parameter NumBands, default 10, number of equalizer bands sequenced per sample.
REQ-002 SHALL have parameter BandBits, default 4, width of band index.
REQ-003 SHALL have parameter SampleWidth, default 16, width of input and output samples.
REQ-004 SHALL have parameter AccWidth, default 36, width of the signed band-sum accumulator.
REQ-005 SHALL have ports: Clk in 1 system clock; Reset in 1 asynchronous active-high reset; one clock, all state on rising Clk.
REQ-006 SHALL have ports PSel, PEnable, PWrite in 1 each, bus write strobes; PWData in 32, command word.
REQ-007 SHALL have ports: FirStart out 1, start pulse to shared FIR engine; FirBand out BandBits, band being computed; FirSample out SampleWidth, current sample.
REQ-008 SHALL have ports: FirDone in 1, engine completion pulse; FirResult in 32, signed band output, valid with FirDone.
REQ-009 SHALL have ports: SampleOut out SampleWidth, equalized sample; SampleValid out 1, one-cycle strobe; Busy out 1; Overrun out 1, sticky drop flag.

Function
REQ-010 Write accepted in any cycle with PSel=PEnable=PWrite=1; opcode = PWData[2:0].
REQ-011 Opcode 2 SHALL write Atten[PWData[6:3]] = PWData[10:7]; band index >= NumBands ignored.
REQ-012 Opcode 3 SHALL submit sample PWData[18:3]; opcode 4 SHALL clear Overrun; all other opcodes ignored.
REQ-013 States: IDLE, ISSUE, WAIT, ACCUM, OUTPUT; only these; any illegal encoding returns to IDLE.
REQ-014 IDLE: on sample submit, latch sample to CurSample, clear Acc, Band=0, next ISSUE.
REQ-015 ISSUE: FirStart=1 for exactly that cycle, FirBand=Band, FirSample=CurSample; next WAIT.
REQ-016 WAIT: hold until FirDone=1; capture FirResult; next ACCUM. No timeout.
REQ-017 ACCUM: Acc += sign-extended FirResult arithmetically right-shifted by Atten[Band], Atten read in this cycle; if Band==NumBands-1 next OUTPUT else Band+1, next ISSUE.
REQ-018 OUTPUT: SampleOut = Acc saturated to signed SampleWidth (max 0x7FFF, min 0x8000); SampleValid=1 one cycle; SampleOut held until next OUTPUT.
REQ-019 OUTPUT: if Pending valid, move to CurSample, clear Pending, clear Acc, Band=0, next ISSUE; else next IDLE.
REQ-020 Busy=1 in every state except IDLE.
REQ-021 Sample submit while Busy: store in one-deep Pending if empty; if Pending full, drop sample and set Overrun=1.
REQ-022 Submit in the same cycle as OUTPUT transfers Pending: the new sample SHALL land in the freed Pending slot, no drop.
REQ-023 Atten writes SHALL be accepted in every state and take effect from the next ACCUM cycle.
REQ-024 FirDone outside WAIT SHALL be ignored.
REQ-025 Latency, submit in IDLE to SampleValid: 1 + NumBands*(2 + engine latency incl. FirDone cycle) + 1 cycles.

Reset
REQ-026 Reset SHALL asynchronously force IDLE, FirStart=0, FirBand=0, FirSample=0, SampleOut=0, SampleValid=0, Busy=0, Overrun=0, Pending empty, Acc=0, all Atten=0.
REQ-027 Reset mid-sequence SHALL abandon the current sample with no SampleValid; FirDone after release while IDLE is ignored.

Structure
REQ-028 Opcode constants (SetAtten=2, Sample=3, ClrOvr=4), state encodings and default widths SHALL live in the shared equalizer package.
REQ-029 Saturation SHALL be one sub-module, sat_round, parameterized on input and output width; no other sub-modules.

Verification
REQ-030 Atten all 0, engine returns 0x100 per band after 3 cycles, submit 0x0010 -> ten FirStart pulses with FirBand 0..9, SampleOut=0x0A00, one SampleValid.
REQ-031 Atten[3]=4 and 0 elsewhere, engine returns 0x100 -> SampleOut=0x0910.
REQ-032 Engine returns 0x7FFF0000 every band -> SampleOut=0x7FFF; returns 0x80000000 -> 0x8000.
REQ-033 Three submits during busy -> second buffered and processed back-to-back, third dropped, Overrun=1; opcode 4 -> Overrun=0.
REQ-034 Reset asserted in WAIT of band 5 -> all outputs at reset values immediately; late FirDone produces no SampleValid.
REQ-035 Submit coincident with OUTPUT while Pending full -> no Overrun; both samples emitted in order.

Source files
------------

// File: rtl/band_scheduler_pkg.sv
// Shared equalizer definitions: default widths, command opcodes and sequencer states.
package band_scheduler_pkg;

    localparam int unsigned NumBandsDefault    = 10;
    localparam int unsigned BandBitsDefault    = 4;
    localparam int unsigned SampleWidthDefault = 16;
    localparam int unsigned AccWidthDefault    = 36;
    localparam int unsigned AttenBits          = 4;

    // Command opcodes carried in PWData[2:0]
    localparam logic [2:0] OpSetAtten = 3'd2;
    localparam logic [2:0] OpSample   = 3'd3;
    localparam logic [2:0] OpClrOvr   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue  = 3'd1,
        StWait   = 3'd2,
        StAccum  = 3'd3,
        StOutput = 3'd4
    } state_e;

endpackage

// File: rtl/band_scheduler_sat_round.sv
// Signed saturation from a wide accumulator down to the output sample width.
module sat_round #(
    parameter int unsigned InWidth  = 36,
    parameter int unsigned OutWidth = 16
) (
    input  logic [InWidth-1:0]  value,
    output logic [OutWidth-1:0] result
);

    // Bits that must all equal the sign bit for the value to be representable
    localparam int unsigned TopBits = InWidth - OutWidth + 1;

    logic [TopBits-1:0] top;
    logic               fits;

    // Pass through when in range, otherwise clamp to the signed max or min
    always_comb begin
        top  = value[InWidth-1 -: TopBits];
        fits = (top == '0) || (top == '1);
        if (fits) begin
            result = value[OutWidth-1:0];
        end else if (value[InWidth-1]) begin
            result = {1'b1, {(OutWidth - 1){1'b0}}};
        end else begin
            result = {1'b0, {(OutWidth - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/band_scheduler.sv
// Sequences one input sample through NumBands passes of a shared FIR engine,
// accumulates the attenuated band outputs and emits a saturated equalized sample.
module band_scheduler
    import band_scheduler_pkg::*;
#(
    parameter int unsigned NumBands    = NumBandsDefault,
    parameter int unsigned BandBits    = BandBitsDefault,
    parameter int unsigned SampleWidth = SampleWidthDefault,
    parameter int unsigned AccWidth    = AccWidthDefault
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   PSel,
    input  logic                   PEnable,
    input  logic                   PWrite,
    input  logic [31:0]            PWData,
    output logic                   FirStart,
    output logic [BandBits-1:0]    FirBand,
    output logic [SampleWidth-1:0] FirSample,
    input  logic                   FirDone,
    input  logic [31:0]            FirResult,
    output logic [SampleWidth-1:0] SampleOut,
    output logic                   SampleValid,
    output logic                   Busy,
    output logic                   Overrun
);

    state_e                           state_q, state_d;
    logic [BandBits-1:0]              band_q, band_d;
    logic [SampleWidth-1:0]           cur_sample_q, cur_sample_d;
    logic [AccWidth-1:0]              acc_q, acc_d;
    logic [31:0]                      fir_res_q, fir_res_d;
    logic                             pending_valid_q, pending_valid_d;
    logic [SampleWidth-1:0]           pending_q, pending_d;
    logic                             overrun_q, overrun_d;
    logic [SampleWidth-1:0]           sample_out_q, sample_out_d;
    logic [NumBands-1:0][AttenBits-1:0] atten_q, atten_d;

    logic                   wr_en;
    logic                   submit;
    logic                   set_atten;
    logic                   clr_ovr;
    logic [SampleWidth-1:0] new_sample;
    logic [AttenBits-1:0]   atten_sel;
    logic signed [AccWidth-1:0] fir_ext;
    logic signed [AccWidth-1:0] shifted;
    logic [AccWidth-1:0]    acc_sum;
    logic [SampleWidth-1:0] sat_out;
    logic                   take_pending;
    logic                   last_band;
    logic                   unused_pwdata;

    assign wr_en      = PSel & PEnable & PWrite;
    assign submit     = wr_en && (PWData[2:0] == OpSample);
    assign set_atten  = wr_en && (PWData[2:0] == OpSetAtten);
    assign clr_ovr    = wr_en && (PWData[2:0] == OpClrOvr);
    assign new_sample = PWData[3 +: SampleWidth];
    // Upper command bits carry nothing
    assign unused_pwdata = ^PWData;

    assign atten_sel = atten_q[band_q];
    assign fir_ext   = {{(AccWidth - 32){fir_res_q[31]}}, fir_res_q};
    assign shifted   = fir_ext >>> atten_sel;
    assign acc_sum   = acc_q + shifted;
    assign last_band = (band_q == BandBits'(NumBands - 1));

    sat_round #(
        .InWidth  (AccWidth),
        .OutWidth (SampleWidth)
    ) u_sat_round (
        .value  (acc_sum),
        .result (sat_out)
    );

    assign FirStart    = (state_q == StIssue);
    assign FirBand     = band_q;
    assign FirSample   = cur_sample_q;
    assign SampleOut   = sample_out_q;
    assign SampleValid = (state_q == StOutput);
    assign Busy        = (state_q != StIdle);
    assign Overrun     = overrun_q;

    // Next-state: band sequencing, accumulation, pending slot and attenuation table
    always_comb begin
        state_d         = state_q;
        band_d          = band_q;
        cur_sample_d    = cur_sample_q;
        acc_d           = acc_q;
        fir_res_d       = fir_res_q;
        pending_valid_d = pending_valid_q;
        pending_d       = pending_q;
        overrun_d       = overrun_q;
        sample_out_d    = sample_out_q;
        atten_d         = atten_q;
        take_pending    = 1'b0;

        if (set_atten && ({28'b0, PWData[6:3]} < NumBands)) begin
            atten_d[PWData[6:3]] = PWData[10:7];
        end

        case (state_q)
            StIdle: begin
                // A sample parked during an OUTPUT cycle with an empty slot starts first
                if (pending_valid_q) begin
                    take_pending = 1'b1;
                    cur_sample_d = pending_q;
                    acc_d        = '0;
                    band_d       = '0;
                    state_d      = StIssue;
                end else if (submit) begin
                    cur_sample_d = new_sample;
                    acc_d        = '0;
                    band_d       = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (FirDone) begin
                    fir_res_d = FirResult;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (last_band) begin
                    sample_out_d = sat_out;
                    state_d      = StOutput;
                end else begin
                    band_d  = band_q + BandBits'(1);
                    state_d = StIssue;
                end
            end
            StOutput: begin
                if (pending_valid_q) begin
                    take_pending = 1'b1;
                    cur_sample_d = pending_q;
                    acc_d        = '0;
                    band_d       = '0;
                    state_d      = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take_pending) begin
            pending_valid_d = 1'b0;
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        // Any submit that does not start the engine directly goes to the one-deep slot
        if (submit && !(state_q == StIdle && !pending_valid_q)) begin
            if (!pending_valid_q || take_pending) begin
                pending_valid_d = 1'b1;
                pending_d       = new_sample;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= StIdle;
            band_q          <= '0;
            cur_sample_q    <= '0;
            acc_q           <= '0;
            fir_res_q       <= '0;
            pending_valid_q <= 1'b0;
            pending_q       <= '0;
            overrun_q       <= 1'b0;
            sample_out_q    <= '0;
            atten_q         <= '0;
        end else begin
            state_q         <= state_d;
            band_q          <= band_d;
            cur_sample_q    <= cur_sample_d;
            acc_q           <= acc_d;
            fir_res_q       <= fir_res_d;
            pending_valid_q <= pending_valid_d;
            pending_q       <= pending_d;
            overrun_q       <= overrun_d;
            sample_out_q    <= sample_out_d;
            atten_q         <= atten_d;
        end
    end

endmodule

// File: tb/tb_band_scheduler.sv
// Randomized self-checking bench for band_scheduler with a FIR engine model and
// a timing/arithmetic reference model of the expected equalized samples.
module tb_band_scheduler;

    localparam int NB = 10;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [15:0] smp;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        PSel = 1'b0;
    logic        PEnable = 1'b0;
    logic        PWrite = 1'b0;
    logic [31:0] PWData = '0;
    logic        FirStart;
    logic [3:0]  FirBand;
    logic [15:0] FirSample;
    logic        FirDone = 1'b0;
    logic [31:0] FirResult = '0;
    logic [15:0] SampleOut;
    logic        SampleValid;
    logic        Busy;
    logic        Overrun;

    int          n_checks = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          eng_lat = 3;
    int          mode = 0;
    logic [31:0] salt = '0;
    bit          spur_en = 1'b0;
    logic [3:0]  atten_m [NB];
    exp_t        exp_q [$];
    int          job_out [$];
    int          last_out = -1000;
    bit          exp_ovr = 1'b0;
    int          exp_band = 0;
    int          fs_count = 0;
    exp_t        mon_e;

    band_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PSel        (PSel),
        .PEnable     (PEnable),
        .PWrite      (PWrite),
        .PWData      (PWData),
        .FirStart    (FirStart),
        .FirBand     (FirBand),
        .FirSample   (FirSample),
        .FirDone     (FirDone),
        .FirResult   (FirResult),
        .SampleOut   (SampleOut),
        .SampleValid (SampleValid),
        .Busy        (Busy),
        .Overrun     (Overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Engine response as a pure function of sample, band and the current scenario
    function automatic logic [31:0] fir_resp(input logic [15:0] s, input logic [3:0] b);
        logic [31:0] r;
        r = ({16'h0, s} * 32'h9E3779B1) ^ ({28'h0, b} * 32'h85EBCA6B) ^ salt;
        case (mode)
            0:       return 32'h0000_0100;
            1:       return 32'h7FFF_0000;
            2:       return 32'h8000_0000;
            3:       return 32'($signed(r) >>> 13);
            default: return r;
        endcase
    endfunction

    function automatic logic [15:0] model_out(input logic [15:0] s);
        longint acc = 0;
        for (int b = 0; b < NB; b++) begin
            acc += longint'($signed(fir_resp(s, 4'(b)))) >>> atten_m[b];
        end
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return 16'(acc);
    endfunction

    // Decide accept/drop and the output cycle from the schedule of accepted jobs
    task automatic model_submit(input int c, input logic [15:0] s);
        int   held = 0;
        int   st;
        exp_t e;
        foreach (job_out[i]) if (job_out[i] > c) held++;
        if (held >= 2) begin
            exp_ovr = 1'b1;
            return;
        end
        if (c > last_out) st = c + 1;
        else if (c == last_out) st = c + 2;  // parked during OUTPUT, starts after one IDLE cycle
        else st = last_out + 1;
        e.cyc = st + NB * (2 + eng_lat);
        e.val = model_out(s);
        e.smp = s;
        exp_q.push_back(e);
        job_out.push_back(e.cyc);
        last_out = e.cyc;
    endtask

    function automatic logic [31:0] cmd_sample(input logic [15:0] s);
        return {13'b0, s, 3'd3};
    endfunction

    function automatic logic [31:0] cmd_atten(input logic [3:0] i, input logic [3:0] a);
        return {21'b0, a, i, 3'd2};
    endfunction

    // One-cycle bus write; entered and left #1 after a rising edge
    task automatic wr(input logic [31:0] d);
        PSel = 1'b1;
        PEnable = 1'b1;
        PWrite = 1'b1;
        PWData = d;
        case (d[2:0])
            3'd2: if (d[6:3] < 4'd10) atten_m[d[6:3]] = d[10:7];
            3'd3: model_submit(cyc, d[18:3]);
            3'd4: exp_ovr = 1'b0;
            default: ;
        endcase
        @(posedge Clk);
        #1;
        PSel = 1'b0;
        PEnable = 1'b0;
        PWrite = 1'b0;
        PWData = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic idle_to(input int t);
        while (cyc < t) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        idle_to(last_out + 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_firstart"}, FirStart, 0);
        check_eq({tag, "_firband"}, FirBand, 0);
        check_eq({tag, "_firsample"}, FirSample, 0);
        check_eq({tag, "_sampleout"}, SampleOut, 0);
        check_eq({tag, "_valid"}, SampleValid, 0);
        check_eq({tag, "_busy"}, Busy, 0);
        check_eq({tag, "_overrun"}, Overrun, 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        job_out.delete();
        last_out = -1000;
        exp_ovr = 1'b0;
        exp_band = 0;
        for (int i = 0; i < NB; i++) atten_m[i] = '0;
    endtask

    // FIR engine: answers each start after eng_lat cycles, optionally injects stray done pulses
    initial begin : engine
        logic [3:0]  eb;
        logic [15:0] es;
        forever begin
            @(negedge Clk);
            FirDone = 1'b0;
            if (FirStart && !Reset) begin
                eb = FirBand;
                es = FirSample;
                repeat (eng_lat) @(negedge Clk);
                FirDone = 1'b1;
                FirResult = fir_resp(es, eb);
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                FirDone = 1'b1;
                FirResult = $urandom;
            end
        end
    end

    // Output monitor: band order, sample fed to the engine, result value and timing
    always @(negedge Clk) begin
        if (!Reset) begin
            if (FirStart) begin
                fs_count++;
                check_eq("fir_band", FirBand, exp_band);
                exp_band = (exp_band == NB - 1) ? 0 : exp_band + 1;
                if (exp_q.size() == 0) check_eq("fir_start_unexpected", FirStart, 0);
                else check_eq("fir_sample", FirSample, exp_q[0].smp);
            end
            if (SampleValid) begin
                if (exp_q.size() == 0) begin
                    check_eq("valid_unexpected", SampleValid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("sample_out", SampleOut, mon_e.val);
                    check_eq("valid_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin : main
        int fs0;
        int c0;
        model_reset();
        #1 Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("por");
        Reset = 1'b0;
        idle_cycles(2);

        // Flat response: ten bands of 0x100
        eng_lat = 3;
        mode = 0;
        fs0 = fs_count;
        wr(cmd_sample(16'h0010));
        check_eq("busy_running", Busy, 1);
        wait_idle();
        check_eq("fir_start_count", fs_count - fs0, 10);
        check_eq("flat_gain", SampleOut, 16'h0A00);

        // Band 3 attenuated by 16
        wr(cmd_atten(4'd3, 4'd4));
        wr(cmd_sample(16'h0010));
        wait_idle();
        check_eq("atten_band3", SampleOut, 16'h0910);
        wr(cmd_atten(4'd3, 4'd0));

        // Saturation both ways
        mode = 1;
        wr(cmd_sample(16'h1234));
        wait_idle();
        check_eq("sat_pos", SampleOut, 16'h7FFF);
        mode = 2;
        wr(cmd_sample(16'h4321));
        wait_idle();
        check_eq("sat_neg", SampleOut, 16'h8000);

        // Three submits while busy: one buffered, one dropped
        mode = 0;
        wr(cmd_sample(16'h0101));
        wr(cmd_sample(16'h0202));
        wr(cmd_sample(16'h0303));
        check_eq("overrun_set", Overrun, 1);
        wait_idle();
        check_eq("overrun_sticky", Overrun, exp_ovr);
        wr(32'd4);
        check_eq("overrun_clr", Overrun, 0);

        // Submit landing on the OUTPUT cycle that frees the pending slot
        mode = 4;
        salt = $urandom;
        c0 = cyc;
        wr(cmd_sample(16'h0A0A));
        wr(cmd_sample(16'h0B0B));
        idle_to(c0 + 1 + NB * (2 + eng_lat));
        wr(cmd_sample(16'h0C0C));
        check_eq("coincident_no_overrun", Overrun, 0);
        wait_idle();
        check_eq("coincident_drained", exp_q.size(), 0);

        // Randomized scenarios
        for (int ph = 0; ph < 6; ph++) begin
            wait_idle();
            eng_lat = $urandom_range(1, 4);
            mode = $urandom_range(0, 4);
            salt = $urandom;
            spur_en = 1'($urandom_range(0, 1));
            repeat (4) wr(cmd_atten(4'($urandom), 4'($urandom)));
            for (int k = 0; k < 6; k++) begin
                wr(cmd_sample(16'($urandom)));
                idle_cycles($urandom_range(0, 70));
            end
            wait_idle();
            check_eq("overrun_model", Overrun, exp_ovr);
            wr(32'd4);
        end

        // Reset while waiting on band 5 with pending full and overrun set
        wait_idle();
        spur_en = 1'b0;
        eng_lat = 6;
        mode = 0;
        wr(cmd_atten(4'd1, 4'd7));
        c0 = cyc;
        wr(cmd_sample(16'h5555));
        wr(cmd_sample(16'h6666));
        wr(cmd_sample(16'h7777));
        idle_to(c0 + 1 + 5 * (eng_lat + 2) + 1);
        check_eq("pre_reset_busy", Busy, 1);
        Reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(posedge Clk);
        #2 Reset = 1'b0;
        idle_cycles(40);
        check_eq("post_reset_busy", Busy, 0);
        check_eq("post_reset_sampleout", SampleOut, 0);

        // Attenuation table cleared by reset
        eng_lat = 2;
        wr(cmd_sample(16'h0001));
        wait_idle();
        check_eq("post_reset_flat", SampleOut, 16'h0A00);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
